// File: rtl/sap1_pkg.sv
// sap1_pkg: shared definitions for the SAP-1 RAM loader slice.
//   - loader_state_e : loader FSM states (also exported on the debug port)
//   - OP_*           : SAP-1 opcodes (upper nibble of an instruction byte)
//   - RAM_*          : SAP-1 program/data RAM geometry
//   - make_instr()   : packs opcode and operand into one RAM word
package sap1_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_ACCEPT  = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_FILL    = 3'd5,
    ST_RELEASE = 3'd6,
    ST_DONE    = 3'd7
  } loader_state_e;

  function automatic logic [RAM_DATA_W-1:0] make_instr(input logic [3:0] op,
                                                       input logic [3:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/sap1_hold_timer.sv
// sap1_hold_timer: loadable down-counter with a zero flag. The loader uses it
// to time how long the CPU clear is held before the first write (HOLD) and
// after the last write (RELEASE).
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low reset (count -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value loaded
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module sap1_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sap1_ram_loader.sv
// sap1_ram_loader: programs the SAP-1 16x8 RAM from a byte stream while
// holding the CPU sequencer/PC in clear, then releases it.
//
// Ports:
//   CLK, CLR          : clock (rising edge), asynchronous active-low reset
//   load_start        : one-cycle pulse, starts a session from IDLE or DONE
//   in_valid/in_ready : byte stream handshake, in_data byte, in_last marks end
//   ram_addr/ram_wdata/ram_we : RAM write port (one strobe cycle per word)
//   cpu_clr_n         : active-low clear to the CPU, low for the whole session
//   busy              : session in progress
//   done              : one-cycle pulse when the session ends
//   err_overflow      : sticky, stream was longer than DEPTH
//   word_count        : stream words written in the current/last session
//   state_dbg         : current FSM state (debug)
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are
// both 1. in_ready depends only on the FSM state, never on in_valid; in_data
// and in_last are only looked at on a transfer edge.
//
// Build option: define LOADER_FILL_EN to pad the remaining RAM addresses with
// FILL_WORD after a short stream. Without it unwritten addresses are untouched.
//
// DEPTH must equal 2**ADDR_W; ram_addr never wraps.
module sap1_ram_loader
  import sap1_pkg::*;
#(
  parameter int                ADDR_W    = RAM_ADDR_W,
  parameter int                DATA_W    = RAM_DATA_W,
  parameter int                DEPTH     = RAM_DEPTH,
  parameter int                HOLD_CYC  = 2,
  parameter logic [DATA_W-1:0] FILL_WORD = {OP_HLT, 4'h0}
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_clr_n,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count,
  output loader_state_e     state_dbg
);

  // Timer is loaded with HOLD_CYC-1 so HOLD and RELEASE each last HOLD_CYC cycles.
  localparam int                TMR_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_inc;
  logic              tmr_load, tmr_dec, tmr_zero;

  assign count_inc = count_q + 1'b1;

  sap1_hold_timer #(.W(TMR_W)) u_hold_timer (
    .clk_i      (CLK),
    .rst_n_i    (CLR),
    .load_i     (tmr_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d  = ST_HOLD;
          addr_d   = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) state_d = ST_ACCEPT;
        else          tmr_dec = 1'b1;
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          wdata_d = in_data;
          last_d  = in_last;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_inc;
        if (last_q) begin
`ifdef LOADER_FILL_EN
          if (count_inc != DEPTH_CNT) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_FILL;
          end else begin
            state_d  = ST_RELEASE;
            tmr_load = 1'b1;
          end
`else
          state_d  = ST_RELEASE;
          tmr_load = 1'b1;
`endif
        end else if (count_inc == DEPTH_CNT) begin
          // RAM is full but the stream has not ended: swallow the rest.
          state_d = ST_DRAIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      ST_DRAIN: begin
        if (in_valid) begin
          ovf_d = 1'b1;
          if (in_last) begin
            state_d  = ST_RELEASE;
            tmr_load = 1'b1;
          end
        end
      end
      ST_FILL: begin
        // Only reachable when padding is built in.
        if (addr_q == ADDR_LAST) begin
          state_d  = ST_RELEASE;
          tmr_load = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode from the state register so an asynchronous reset drops
  // ram_we and releases cpu_clr_n immediately.
  assign in_ready     = (state_q == ST_ACCEPT) || (state_q == ST_DRAIN);
  assign ram_we       = (state_q == ST_WRITE) || (state_q == ST_FILL);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign cpu_clr_n    = ~busy;
  assign ram_addr     = addr_q;
  assign ram_wdata    = (state_q == ST_FILL) ? FILL_WORD : wdata_q;
  assign done         = done_q;
  assign err_overflow = ovf_q;
  assign word_count   = count_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/sap1_ram_loader.md
Name: sap1_ram_loader

Overview:
- Controller that programs the SAP-1 16x8 program/data RAM from an external byte stream. It holds the CPU sequencer in reset while loading, then releases it.
- Sits between the front-panel/serial input path and the RAM's write port.
- Owns the RAM write port and the CPU clear line during a load. When idle, it is transparent: no writes, CPU clear is released.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- DEPTH, 16, number of RAM words. Must equal 2**ADDR_W.
- HOLD_CYC, 2, minimum cycles cpu_clr_n is held low before the first write and after the last write.
- FILL_WORD, 8'hF0, fill value used by the optional feature (HLT opcode).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; starts a load session. Ignored unless in IDLE or DONE.
- in_valid  in  1  input byte valid.
- in_data  in  DATA_W  input byte.
- in_last  in  1  marks the final byte; qualified by in_valid & in_ready.
- in_ready  out  1  loader accepts a byte this cycle.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write strobe, one cycle per word.
- cpu_clr_n  out  1  active-low clear to Controller_Sequencer/PC.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- err_overflow  out  1  sticky; set when the stream exceeds DEPTH. Cleared by load_start or CLR.
- word_count  out  ADDR_W+1  words written in the current/last session.

Behaviour:
- Reset (CLR low, async):
  - state=IDLE; all outputs 0 except cpu_clr_n=1.
  - ram_addr=0, word_count=0, err_overflow=0.
  - Reset mid-session aborts immediately. Words already written stay in RAM.
- States:
  - IDLE/DONE: on load_start, go to HOLD. Clear word_count, ram_addr and err_overflow; drive cpu_clr_n=0 and busy=1.
  - HOLD: counter counts HOLD_CYC cycles, then go to ACCEPT.
  - ACCEPT: in_ready=1. On in_valid, register in_data into ram_wdata, register in_last into last_f, and go to WRITE.
  - WRITE: ram_we=1 for exactly one cycle at ram_addr; in_ready=0; word_count+1.
    - If last_f: go to RELEASE (or FILL when LOADER_FILL_EN is defined).
    - Else if word_count+1==DEPTH: go to DRAIN.
    - Else: ram_addr+1 and go to ACCEPT.
  - DRAIN: in_ready=1 and bytes are discarded. Any accepted byte sets err_overflow. Accepting in_last goes to RELEASE.
  - RELEASE: cpu_clr_n stays 0 for HOLD_CYC cycles. Then set cpu_clr_n=1, busy=0, pulse done=1, and go to DONE.
- Throughput: one word per 2 cycles maximum; ACCEPT and WRITE alternate.
- Latency: the byte accepted at edge N is written at edge N+1.
- Boundary conditions:
  - ram_addr never wraps. The last write is at DEPTH-1.
  - The 16th byte with in_last is legal and does not set overflow.
  - The 16th byte without in_last goes to DRAIN.
  - in_valid outside ACCEPT/DRAIN is ignored and never written.
  - load_start while busy is ignored.
  - load_start in the same cycle as done: the session ends normally, and the new start is taken on the next cycle from DONE.
  - An empty session is impossible: a session needs at least one byte.

Optional Feature:
- LOADER_FILL_EN defined: after the last write, if word_count<DEPTH, enter FILL. FILL writes FILL_WORD to each remaining address, one per cycle with ram_we=1 and in_ready=0, then goes to RELEASE. word_count counts only stream words.
- LOADER_FILL_EN undefined: no FILL state; unwritten addresses keep their old contents.

Decomposition:
- Package sap1_pkg holds:
  - the loader state enum (IDLE, HOLD, ACCEPT, WRITE, DRAIN, FILL, RELEASE, DONE);
  - SAP-1 opcode constants (LDA=0, ADD=1, SUB=2, OUT=14, HLT=15);
  - RAM geometry constants.
- One sub-module, sap1_hold_timer: loadable down-counter with a zero flag, shared by HOLD and RELEASE.

Test Plan:
- Reset/idle: CLR low for 1 cycle then high, no load_start -> cpu_clr_n=1, ram_we never 1, in_ready=0, busy=0.
- Normal load: load_start, then bytes 0x09,0x1A,0x2B,0xE0,0xF0 with last on 0xF0 -> writes addr 0..4 with those values, word_count=5, one done pulse, cpu_clr_n low from load_start to HOLD_CYC cycles after the last write, err_overflow=0.
- Full load: 16 bytes 0x00..0x0F, last on the 16th -> addr 0..15 written, word_count=16, no overflow.
- Overflow: 18 bytes, last on the 18th -> 16 writes only, no write after addr 15, err_overflow=1 after done.
- Back-pressure/abort: in_valid low for 5 cycles mid-stream -> no writes during the gap. Then CLR low during WRITE -> cpu_clr_n=1 and busy=0 immediately, no further ram_we.
- LOADER_FILL_EN: 3-byte load -> addr 3..15 written with 0xF0, word_count=3.
